// File: rtl/sram_init_pkg.sv
// Shared state encoding, response flag layout and parameter defaults for the SRAM port initiator.
package sram_init_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_e;

  // Width-independent part of a response; the top pairs it with rdata of its own DATA_WIDTH.
  typedef struct packed {
    logic we;
    logic err;
  } rsp_flags_t;

  localparam int unsigned DEFAULT_TIMEOUT   = 255;
  localparam int unsigned DEFAULT_RSP_DEPTH = 2;

endpackage

// File: rtl/sram_init_rsp_fifo.sv
// Synchronous response FIFO with occupancy count; simultaneous push and pop are both honoured.
module sram_init_rsp_fifo #(
  parameter type             rsp_t = logic,
  parameter int unsigned     DEPTH = 2,
  localparam int unsigned    CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push,
  input  rsp_t          wdata,
  input  logic          pop,
  output rsp_t          rdata,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rsp_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the storage is reset too, so the head (and thus rsp_*) reads 0 straight out of reset.
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/sram_port_initiator.sv
// Initiator side of the SRAM req/gnt/rvalid/rready port: one transaction at a time, buffered responses,
// per-transaction timeout and error accounting. Define SRAM_INIT_PARITY_CHECK_EN to check gnt/rvalid parity.
module sram_port_initiator
  import sram_init_pkg::*;
#(
  parameter int unsigned  DATA_WIDTH   = 32,
  parameter int unsigned  NUM_WORDS    = 1024,
  parameter int unsigned  RSP_DEPTH    = DEFAULT_RSP_DEPTH,
  parameter int unsigned  TIMEOUT      = DEFAULT_TIMEOUT,
  parameter int unsigned  ERRCNT_WIDTH = 8,
  localparam int unsigned ADDR_WIDTH   = $clog2(NUM_WORDS),
  localparam int unsigned BE_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_we_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  input  logic [BE_WIDTH-1:0]     cmd_be_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_we_o,
  output logic                    rsp_err_o,
  output logic                    sram_req_o,
  output logic                    sram_we_o,
  output logic [ADDR_WIDTH-1:0]   sram_addr_o,
  output logic [DATA_WIDTH-1:0]   sram_wdata_o,
  output logic [BE_WIDTH-1:0]     sram_be_o,
  output logic                    sram_rready_o,
  input  logic                    sram_gnt_i,
  input  logic                    sram_gntpar_i,
  input  logic                    sram_rvalid_i,
  input  logic                    sram_rvalidpar_i,
  input  logic [DATA_WIDTH-1:0]   sram_rdata_i,
  output logic                    err_o,
  input  logic                    err_clr_i,
  output logic [ERRCNT_WIDTH-1:0] err_cnt_o
);

  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    rsp_flags_t            flags;
  } rsp_t;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          err_pending_q, err_pending_d;
  logic          accept;
  logic          par_fault;
  logic          push;
  logic          pop;
  rsp_t          push_data;
  rsp_t          head;
  logic [CW-1:0] fifo_count;

  // A free FIFO slot is checked at accept time, so the in-flight transaction always has room to push.
  assign cmd_ready_o   = (state_q == IDLE) && (fifo_count < CW'(RSP_DEPTH));
  assign accept        = cmd_valid_i && cmd_ready_o;
  assign sram_req_o    = (state_q == REQ);
  assign sram_rready_o = (state_q == RESP);

`ifdef SRAM_INIT_PARITY_CHECK_EN
  assign par_fault = (sram_gntpar_i == sram_gnt_i) || (sram_rvalidpar_i == sram_rvalid_i);
`else
  logic unused_parity;
  assign unused_parity = sram_gntpar_i ^ sram_rvalidpar_i;
  assign par_fault     = 1'b0;
`endif

  always_comb begin
    // NOTE: defaults first, so no path through the case below leaves a signal unassigned (no latches).
    state_d       = state_q;
    timer_d       = timer_q;
    err_pending_d = err_pending_q;
    push          = 1'b0;
    push_data     = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d       = REQ;
          timer_d       = '0;
          err_pending_d = 1'b0;
        end
      end
      REQ, RESP: begin
        if (par_fault) err_pending_d = 1'b1;
        if (state_q == REQ && sram_gnt_i) begin
          state_d = RESP;
          timer_d = '0;
        end else if (state_q == RESP && sram_rvalid_i) begin
          push                = 1'b1;
          push_data.flags.we  = sram_we_o;
          push_data.flags.err = err_pending_d;
          push_data.rdata     = (sram_we_o || err_pending_d) ? '0 : sram_rdata_i;
          state_d             = IDLE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          push                = 1'b1;
          push_data.flags.we  = sram_we_o;
          push_data.flags.err = 1'b1;
          state_d             = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      err_pending_q <= 1'b0;
      sram_we_o     <= 1'b0;
      sram_addr_o   <= '0;
      sram_wdata_o  <= '0;
      sram_be_o     <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      err_pending_q <= err_pending_d;
      if (accept) begin
        sram_we_o    <= cmd_we_i;
        sram_addr_o  <= cmd_addr_i;
        sram_wdata_o <= cmd_wdata_i;
        sram_be_o    <= cmd_be_i;
      end
    end
  end

  // Clear wins over a same-cycle errored push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_o     <= 1'b0;
      err_cnt_o <= '0;
    end else if (err_clr_i) begin
      err_o     <= 1'b0;
      err_cnt_o <= '0;
    end else if (push && push_data.flags.err) begin
      err_o <= 1'b1;
      if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + 1'b1;
    end
  end

  sram_init_rsp_fifo #(
    .rsp_t (rsp_t),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .wdata  (push_data),
    .pop    (pop),
    .rdata  (head),
    .count  (fifo_count)
  );

  assign rsp_valid_o = (fifo_count != '0);
  assign pop         = rsp_valid_o && rsp_ready_i;
  assign rsp_rdata_o = head.rdata;
  assign rsp_we_o    = head.flags.we;
  assign rsp_err_o   = head.flags.err;

endmodule
